// File: rtl/sram_mrmw_pipe_if.sv
// Port bundle for the multi-read/multi-write register-file SRAM.
// master drives requests; slave is the array.
interface sram_mrmw_pipe_if #(
   parameter int NUM_RD = 8,
   parameter int NUM_WR = 4,
   parameter int INDEX  = 6,
   parameter int WIDTH  = 8
);
   logic [NUM_RD-1:0]       rd_en_i;
   logic [NUM_RD*INDEX-1:0] rd_addr_i;
   logic [NUM_RD*WIDTH-1:0] rd_data_o;
   logic [NUM_RD-1:0]       rd_valid_o;
   logic [NUM_WR-1:0]       wr_en_i;
   logic [NUM_WR*INDEX-1:0] wr_addr_i;
   logic [NUM_WR*WIDTH-1:0] wr_data_i;
   logic                    wr_conflict_o;
   logic                    init_busy_o;

   modport master (
      output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
      input  rd_data_o, rd_valid_o, wr_conflict_o, init_busy_o
   );

   modport slave (
      input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
      output rd_data_o, rd_valid_o, wr_conflict_o, init_busy_o
   );
endinterface

// File: rtl/sram_mrmw_pipe.sv
// Multi-read/multi-write register-file SRAM with registered reads and a
// post-reset clear walk; SRAM_MRMW_WR_BYPASS_EN makes reads write-first.
module sram_mrmw_pipe #(
   parameter int DEPTH    = 64,
   parameter int INDEX    = 6,
   parameter int WIDTH    = 8,
   parameter int NUM_RD   = 8,
   parameter int NUM_WR   = 4,
   parameter int CLR_BASE = 0
) (
   input logic             clk,
   input logic             reset,
   sram_mrmw_pipe_if.slave bus
);

   localparam logic [INDEX:0] ONE     = 1;
   localparam logic [INDEX:0] DEPTH_W = DEPTH[INDEX:0];
   localparam logic [INDEX:0] LAST    = DEPTH_W - ONE;
   localparam logic [INDEX:0] BASE    = CLR_BASE[INDEX:0];

   typedef enum logic {INIT, READY} state_t;

   state_t                  state, state_nxt;
   logic [INDEX:0]          clr_ptr, clr_nxt;
   logic                    busy;
   logic [WIDTH-1:0]        mem [DEPTH];
   logic [WIDTH-1:0]        rd_word [NUM_RD];
   logic [NUM_WR-1:0]       wr_ok;
   logic                    conflict;
   logic [NUM_RD*WIDTH-1:0] rd_data_q;
   logic [NUM_RD-1:0]       rd_valid_q;
   logic                    conflict_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= INIT;
         clr_ptr <= BASE;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_nxt;
      end
   end

   // Pointer may start at DEPTH, so >= LAST also covers an empty walk.
   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_ptr;
      unique case (state)
         INIT: begin
            clr_nxt = clr_ptr + ONE;
            if (clr_ptr >= LAST) state_nxt = READY;
         end
         READY: ;
      endcase
   end

   always_comb begin
      busy = (state == INIT);
   end

   always_comb begin
      wr_ok = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_ok[w] = bus.wr_en_i[w] &&
                    ({1'b0, bus.wr_addr_i[w*INDEX +: INDEX]} < DEPTH_W);
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (wr_ok[i] && wr_ok[j] &&
                bus.wr_addr_i[i*INDEX +: INDEX] ==
                bus.wr_addr_i[j*INDEX +: INDEX])
               conflict = 1'b1;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_word[p] = '0;
         if ({1'b0, bus.rd_addr_i[p*INDEX +: INDEX]} < DEPTH_W) begin
            rd_word[p] = mem[bus.rd_addr_i[p*INDEX +: INDEX]];
`ifdef SRAM_MRMW_WR_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_ok[w] && bus.wr_addr_i[w*INDEX +: INDEX] ==
                               bus.rd_addr_i[p*INDEX +: INDEX])
                  rd_word[p] = bus.wr_data_i[w*WIDTH +: WIDTH];
            end
`endif
         end
      end
   end

   // Higher-numbered ports are assigned last, so they win collisions.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            if (clr_ptr < DEPTH_W) mem[clr_ptr[INDEX-1:0]] <= '0;
         end else begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_ok[w])
                  mem[bus.wr_addr_i[w*INDEX +: INDEX]] <=
                     bus.wr_data_i[w*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || busy) begin
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         conflict_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en_i;
         conflict_q <= conflict;
         for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_en_i[p]) rd_data_q[p*WIDTH +: WIDTH] <= rd_word[p];
         end
      end
   end

   assign bus.rd_data_o     = rd_data_q;
   assign bus.rd_valid_o    = rd_valid_q;
   assign bus.wr_conflict_o = conflict_q;
   assign bus.init_busy_o   = busy;

endmodule
